// File: rtl/cgra_pkg.sv
// Shared CGRA definitions: datapath width and the load/store unit FSM encoding.
// Imported by rc_lsu and rc_lsu_ptr.
package cgra_pkg;

    localparam int DP_WIDTH       = 32;
    localparam int LSU_DEF_STRIDE = 4;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_RESP
    } lsu_state_e;

endpackage

// File: rtl/rc_lsu_ptr.sv
// Direct-access pointer for rc_lsu: host load takes priority over the
// post-grant increment by a sign-extended stride.
module rc_lsu_ptr
    import cgra_pkg::*;
#(
    parameter int DP_WIDTH     = cgra_pkg::DP_WIDTH,
    parameter int STRIDE_WIDTH = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           load_i,
    input  logic        [DP_WIDTH-1:0]     base_i,
    input  logic                           inc_i,
    input  logic signed [STRIDE_WIDTH-1:0] stride_i,
    output logic        [DP_WIDTH-1:0]     ptr_o
);

    function automatic logic signed [DP_WIDTH-1:0] sext_stride(
        input logic signed [STRIDE_WIDTH-1:0] s
    );
        return {{(DP_WIDTH-STRIDE_WIDTH){s[STRIDE_WIDTH-1]}}, s};
    endfunction

    logic signed [DP_WIDTH-1:0] stride_ext;
    assign stride_ext = sext_stride(stride_i);

    // Addition wraps modulo 2^DP_WIDTH; a negative stride walks downward.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_o <= '0;
        end else if (load_i) begin
            ptr_o <= base_i;
        end else if (inc_i) begin
            ptr_o <= ptr_o + stride_ext;
        end
    end

endmodule

// File: rtl/rc_lsu.sv
// Per-cell load/store unit: one outstanding req/gnt/rvalid bus transaction.
// Optional macro RC_LSU_MISALIGN_CHECK_EN adds err_o and suppresses misaligned accesses.
module rc_lsu
    import cgra_pkg::*;
#(
    parameter int DP_WIDTH     = cgra_pkg::DP_WIDTH,
    parameter int STRIDE_WIDTH = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           ptr_load_i,
    input  logic        [DP_WIDTH-1:0]     ptr_base_i,
    input  logic signed [STRIDE_WIDTH-1:0] ptr_stride_i,
    input  logic                           dp_req_i,
    input  logic                           dp_wen_i,
    input  logic                           dp_ind_i,
    input  logic        [DP_WIDTH-1:0]     dp_add_i,
    input  logic        [DP_WIDTH-1:0]     dp_wdata_i,
    output logic        [DP_WIDTH-1:0]     dp_rdata_o,
    output logic                           dp_rvalid_o,
    output logic                           lsu_stall_o,
    output logic                           bus_req_o,
    input  logic                           bus_gnt_i,
    output logic                           bus_we_o,
    output logic        [DP_WIDTH-1:0]     bus_add_o,
    output logic        [DP_WIDTH-1:0]     bus_wdata_o,
    input  logic        [DP_WIDTH-1:0]     bus_rdata_i,
    input  logic                           bus_rvalid_i,
    output logic        [DP_WIDTH-1:0]     ptr_o
`ifdef RC_LSU_MISALIGN_CHECK_EN
    ,
    output logic                           err_o
`endif
);

    lsu_state_e            state_q;
    logic                  ind_q;
    logic                  mis_q;
    logic [DP_WIDTH-1:0]   addr_sel;
    logic                  misaligned;
    logic                  resp_done;
    logic                  ptr_inc;

    assign addr_sel = dp_ind_i ? dp_add_i : ptr_o;

`ifdef RC_LSU_MISALIGN_CHECK_EN
    assign misaligned = |addr_sel[1:0];
    assign err_o      = resp_done & mis_q;
`else
    assign misaligned = 1'b0;
`endif

    // A suppressed misaligned access completes without waiting for the bus.
    assign resp_done   = (state_q == LSU_RESP) & (bus_rvalid_i | mis_q);
    assign dp_rvalid_o = resp_done;
    assign dp_rdata_o  = (resp_done && !bus_we_o && !mis_q) ? bus_rdata_i : '0;
    assign lsu_stall_o = ((state_q == LSU_IDLE) & dp_req_i)
                       | (state_q == LSU_REQ)
                       | ((state_q == LSU_RESP) & ~resp_done);

    assign ptr_inc = (state_q == LSU_REQ) & bus_gnt_i & ~ind_q;

    rc_lsu_ptr #(
        .DP_WIDTH     (DP_WIDTH),
        .STRIDE_WIDTH (STRIDE_WIDTH)
    ) u_ptr (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (ptr_load_i),
        .base_i   (ptr_base_i),
        .inc_i    (ptr_inc),
        .stride_i (ptr_stride_i),
        .ptr_o    (ptr_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= LSU_IDLE;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_add_o   <= '0;
            bus_wdata_o <= '0;
            ind_q       <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            case (state_q)
                LSU_IDLE: begin
                    if (dp_req_i) begin
                        bus_we_o    <= ~dp_wen_i;
                        bus_add_o   <= addr_sel;
                        bus_wdata_o <= dp_wdata_i;
                        ind_q       <= dp_ind_i;
                        mis_q       <= misaligned;
                        if (misaligned) begin
                            state_q <= LSU_RESP;
                        end else begin
                            state_q   <= LSU_REQ;
                            bus_req_o <= 1'b1;
                        end
                    end
                end
                LSU_REQ: begin
                    if (bus_gnt_i) begin
                        state_q   <= LSU_RESP;
                        bus_req_o <= 1'b0;
                    end
                end
                LSU_RESP: begin
                    if (resp_done) begin
                        state_q <= LSU_IDLE;
                        mis_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= LSU_IDLE;
                    bus_req_o <= 1'b0;
                end
            endcase
        end
    end

    // The datapath must hold its request until the response is returned.
    property p_req_held;
        @(posedge clk_i) disable iff (rst_i)
            ((state_q != LSU_IDLE) && !resp_done) |-> dp_req_i;
    endproperty
    a_req_held: assert property (p_req_held)
        else $error("rc_lsu: dp_req_i dropped before response");

endmodule
